sw4_debounce: RTL

- Input-conditioning stage directly upstream of the 4-input combinational logic function block.
- Synchronizes and debounces four raw switch inputs and drives the stable X1..X4 operands that feed that block.
- Also flags when the operand vector changes, so downstream logic can sample it once per change.

---
 rtl/sw_pkg.sv | 13 +
 rtl/sw_debounce_bit.sv | 82 ++++++++
 rtl/sw4_debounce.sv | 91 +++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared constants and FSM state type for the four-switch debounce front end.
package sw_pkg;

    localparam int NUM_SW              = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int SYNC_STAGES_DEF     = 2;

    typedef enum logic {
        DB_MATCH   = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: synchronizer chain, mismatch counter and MATCH/PENDING FSM.
// Exports the debounced level, a flip strobe (asserted in the cycle before level changes) and a pending flag.
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic sample_en,
    output logic level,
    output logic flip,
    output logic pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    db_state_t              state_q, state_d;
    logic                   mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            state_q <= DB_MATCH;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
        mismatch = sync_q[SYNC_STAGES-1] ^ level_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        state_d  = state_q;
        flip     = 1'b0;

        // Only strobed samples advance or clear the count; bounces between strobes are ignored.
        if (sample_en) begin
            case (state_q)
                DB_MATCH: begin
                    if (mismatch) begin
                        cnt_d   = CNT_W'(1);
                        state_d = DB_PENDING;
                    end
                end
                DB_PENDING: begin
                    if (!mismatch) begin
                        cnt_d   = '0;
                        state_d = DB_MATCH;
                    end else if (cnt_q == CNT_LAST) begin
                        flip    = 1'b1;
                        level_d = ~level_q;
                        cnt_d   = '0;
                        state_d = DB_MATCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = DB_MATCH;
                end
            endcase
        end
    end

    assign level   = level_q;
    assign pending = (cnt_q != '0);

endmodule

// File: rtl/sw4_debounce.sv
// Four-switch synchronize/debounce stage producing X1..X4, a change pulse and a stable flag.
// Define SW4_EDGE_EN to add per-bit rise_pulse/fall_pulse outputs.
module sw4_debounce
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic              sample_en,
    output logic              X1,
    output logic              X2,
    output logic              X3,
    output logic              X4,
    output logic              changed,
`ifdef SW4_EDGE_EN
    output logic [NUM_SW-1:0] rise_pulse,
    output logic [NUM_SW-1:0] fall_pulse,
`endif
    output logic              stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [NUM_SW-1:0] level, flip, pending;
    logic              changed_q, changed_d;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .raw_in    (sw_raw[i]),
            .sample_en (sample_en),
            .level     (level[i]),
            .flip      (flip[i]),
            .pending   (pending[i])
        );
    end

    // Registering the flip strobes lines the pulses up with the new X value.
    always_comb begin
        changed_d = |flip;
    end

`ifdef SW4_EDGE_EN
    logic [NUM_SW-1:0] rise_q, rise_d;
    logic [NUM_SW-1:0] fall_q, fall_d;

    always_comb begin
        rise_d = flip & ~level;
        fall_d = flip & level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            changed_q <= changed_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end
`endif

    assign X1      = level[0];
    assign X2      = level[1];
    assign X3      = level[2];
    assign X4      = level[3];
    assign changed = changed_q;
    assign stable  = ~|pending;

endmodule
